vga_fb_reader: RTL and testbench



---
 rtl/vga_fb_reader.sv | 79 +++++++
 tb/tb_vga_fb_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: framebuffer pixel fetch behind the VGA sync core, multiplier-free addressing, sync delay matched to read latency.
// Define VGA_FB_SCALE2_EN for 2x pixel doubling from a half-resolution framebuffer.
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
module vga_fb_reader #(
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int RGB_SIZE   = 12,
  parameter int RD_LATENCY = 2,
  parameter int FB_AW      = 19
) (
  input  logic                pixel_clk,
  input  logic                pixel_rst_n,
  input  logic                sync_hsync,
  input  logic                sync_vsync,
  input  logic [`H_SIZE-1:0]  sync_hc,
  input  logic [`V_SIZE-1:0]  sync_vc,
  input  logic                sync_on,
  output logic                fb_rd,
  output logic [FB_AW-1:0]    fb_addr,
  input  logic [RGB_SIZE-1:0] fb_rdata,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_on,
  output logic [RGB_SIZE-1:0] vga_rgb,
  output logic                frame_start
);
  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
  state_t r_state, w_state_nx;
  logic w_fstart, w_active, w_on, w_line_end;
  logic [FB_AW-1:0] r_line_base, r_pix_addr, w_base, w_addr, w_base_nx, w_pix_nx;
  logic [3:0] r_dly [0:RD_LATENCY];
  // Frame start overrides the counters combinationally so pixel (0,0) itself reads address 0.
  always_comb begin
    w_fstart   = sync_on && sync_hc == '0 && sync_vc == '0;
    w_active   = r_state == ACTIVE || w_fstart;
    w_on       = sync_on && w_active && sync_vc < `V_SIZE'(V_DISPLAY);
    w_line_end = sync_hc == `H_SIZE'(H_DISPLAY - 1);
    w_state_nx = w_active ? ACTIVE : WAIT_FRAME;
    w_base     = w_fstart ? '0 : r_line_base;
    w_addr     = w_fstart ? '0 : r_pix_addr;
`ifdef VGA_FB_SCALE2_EN
    w_base_nx  = (w_on && w_line_end && sync_vc[0]) ? w_base + FB_AW'(H_DISPLAY / 2) : w_base;
    w_pix_nx   = !w_on ? w_addr : w_line_end ? w_base_nx : w_addr + FB_AW'(sync_hc[0]);
`else
    w_base_nx  = (w_on && w_line_end) ? w_base + FB_AW'(H_DISPLAY) : w_base;
    w_pix_nx   = !w_on ? w_addr : w_line_end ? w_base_nx : w_addr + FB_AW'(1);
`endif
  end
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_state     <= WAIT_FRAME;
      r_line_base <= '0;
      r_pix_addr  <= '0;
      fb_rd       <= 1'b0;
      fb_addr     <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_on      <= 1'b0;
      frame_start <= 1'b0;
      vga_rgb     <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) r_dly[i] <= 4'b1100;
    end else begin
      r_state     <= w_state_nx;
      r_line_base <= w_base_nx;
      r_pix_addr  <= w_pix_nx;
      fb_rd       <= w_on;
      if (w_on) fb_addr <= w_addr;
      r_dly[0]    <= {sync_hsync, sync_vsync, w_on, w_fstart};
      for (int i = 1; i <= RD_LATENCY; i++) r_dly[i] <= r_dly[i-1];
      {vga_hsync, vga_vsync, vga_on, frame_start} <= r_dly[RD_LATENCY];
      vga_rgb     <= r_dly[RD_LATENCY][1] ? fb_rdata : '0;
    end
  end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: scoreboard bench on a reduced raster; second instance with RD_LATENCY=1 checks 3-cycle alignment.
module tb_vga_fb_reader;
  localparam int H = 64, V = 48, HT = 80, VT = 56, AW = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic hs = 1'b1, vs = 1'b1, on = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic rd, rd1, vh, vh1, vv, vv1, von, von1, fs, fs1;
  logic [AW-1:0] addr, addr1;
  logic [11:0] rdata, rdata1, rgb, rgb1, p1;
  logic [11:0] p2 [0:1];
  vga_fb_reader #(.H_DISPLAY(H), .V_DISPLAY(V), .RGB_SIZE(12), .RD_LATENCY(2), .FB_AW(AW)) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .sync_hsync(hs), .sync_vsync(vs), .sync_hc(hc), .sync_vc(vc),
    .sync_on(on), .fb_rd(rd), .fb_addr(addr), .fb_rdata(rdata), .vga_hsync(vh), .vga_vsync(vv),
    .vga_on(von), .vga_rgb(rgb), .frame_start(fs));
  vga_fb_reader #(.H_DISPLAY(H), .V_DISPLAY(V), .RGB_SIZE(12), .RD_LATENCY(1), .FB_AW(AW)) dut1 (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .sync_hsync(hs), .sync_vsync(vs), .sync_hc(hc), .sync_vc(vc),
    .sync_on(on), .fb_rd(rd1), .fb_addr(addr1), .fb_rdata(rdata1), .vga_hsync(vh1), .vga_vsync(vv1),
    .vga_on(von1), .vga_rgb(rgb1), .frame_start(fs1));
  // Memory returns the low address bits when read, 0xFFF otherwise so blanking is visible.
  always @(posedge clk) begin
    p2[0] <= rd ? addr[11:0] : 12'hFFF;
    p2[1] <= p2[0];
    p1    <= rd1 ? addr1[11:0] : 12'hFFF;
  end
  assign rdata  = p2[1];
  assign rdata1 = p1;
  typedef struct {int due; logic rd; logic [AW-1:0] a;} rd_t;
  typedef struct {int due; logic hs, vs, on, fs; logic [11:0] rgb;} out_t;
  rd_t rq[$];
  out_t oq[$], oq1[$];
  int cyc = 0, checks = 0, fails = 0, h = 20, v = 30;
  logic [AW-1:0] maxa = '0;
  bit locked = 1'b0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic drive();
    logic [AW-1:0] ea;
    logic lk;
    out_t o;
    @(negedge clk);
    hc = 10'(h);
    vc = 10'(v);
    on = h < H && v < V;
    hs = !(h >= H + 4 && h < H + 12);
    vs = !(v >= V + 2 && v < V + 5);
    if (rst_n) begin
      if (on && h == 0 && v == 0) locked = 1'b1;
`ifdef VGA_FB_SCALE2_EN
      ea = AW'((v / 2) * (H / 2) + h / 2);
`else
      ea = AW'(v * H + h);
`endif
      lk = locked && on;
      rq.push_back('{cyc + 1, lk, lk ? ea : '0});
      o = '{cyc + 4, hs, vs, lk, lk && h == 0 && v == 0, lk ? ea[11:0] : 12'h000};
      oq.push_back(o);
      o.due = cyc + 3;
      oq1.push_back(o);
    end
    h = (h == HT - 1) ? 0 : h + 1;
    if (h == 0) v = (v == VT - 1) ? 0 : v + 1;
  endtask
  task automatic check_idle();
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_hsync", 32'(vh), 32'd1);
    check("rst_vsync", 32'(vv), 32'd1);
    check("rst_on", 32'(von), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_rd1", 32'(rd1), 32'd0);
    check("rst_hsync1", 32'(vh1), 32'd1);
    check("rst_rgb1", 32'(rgb1), 32'd0);
  endtask
  initial begin : mon
    rd_t r;
    out_t o;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        check("fb_rd", 32'(rd), 32'(r.rd));
        check("fb_rd1", 32'(rd1), 32'(r.rd));
        if (r.rd) begin
          check("fb_addr", 32'(addr), 32'(r.a));
          check("fb_addr1", 32'(addr1), 32'(r.a));
        end
      end
      while (oq.size() > 0 && oq[0].due == cyc) begin
        o = oq.pop_front();
        check("hsync", 32'(vh), 32'(o.hs));
        check("vsync", 32'(vv), 32'(o.vs));
        check("vga_on", 32'(von), 32'(o.on));
        check("rgb", 32'(rgb), 32'(o.rgb));
        check("frame_start", 32'(fs), 32'(o.fs));
      end
      while (oq1.size() > 0 && oq1[0].due == cyc) begin
        o = oq1.pop_front();
        check("hsync_l1", 32'(vh1), 32'(o.hs));
        check("vsync_l1", 32'(vv1), 32'(o.vs));
        check("vga_on_l1", 32'(von1), 32'(o.on));
        check("rgb_l1", 32'(rgb1), 32'(o.rgb));
        check("frame_start_l1", 32'(fs1), 32'(o.fs));
      end
      if (rd && addr > maxa) maxa = addr;
    end
  end
  initial begin
    repeat (4) drive();
    @(posedge clk);
    #1;
    check_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * HT * VT; i++) drive();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle();
    rq.delete();
    oq.delete();
    oq1.delete();
    locked = 1'b0;
    repeat (3) drive();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * HT * VT; i++) drive();
    repeat (6) @(posedge clk);
    #2;
    check("drain_rq", 32'(rq.size()), 32'd0);
    check("drain_oq", 32'(oq.size()), 32'd0);
    check("drain_oq1", 32'(oq1.size()), 32'd0);
`ifdef VGA_FB_SCALE2_EN
    check("addr_max", 32'(maxa), 32'(H * V / 4 - 1));
`else
    check("addr_max", 32'(maxa), 32'(H * V - 1));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
